// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package if_fetch_queue_pkg;

    // Default datapath widths
    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;

    // Byte distance between consecutive instruction words
    localparam int PC_INC     = 4;

    // Fetch address after reset
    localparam int PC_RESET   = 0;

    // Width of an occupancy counter able to hold the value 'depth'
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_queue_fifo.sv
// In-order {pc, instr} queue between instruction memory and decode.
// Flush overrides push and pop; push into a full queue is accepted only
// when a pop frees a slot in the same cycle.
module if_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int PC_W    = PC_SIZE,
    parameter int INSTR_W = INSTR_SIZE,
    parameter int DEPTH   = 4,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic               pop_i,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    assign head_pc_o    = pc_mem[rd_ptr_q];
    assign head_instr_o = instr_mem[rd_ptr_q];

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while the slot is occupied
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            pc_mem[wr_ptr_q]    <= push_pc_i;
            instr_mem[wr_ptr_q] <= push_instr_i;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues imem requests from fetch_pc, tags each
// returned word with its PC and queues it for decode. A redirect flushes the
// queue and marks every in-flight response to be discarded.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int PC_W    = PC_SIZE,
    parameter int INSTR_W = INSTR_SIZE,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    input  logic               dec_ready
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]   q_count;
    logic               q_empty;
    logic [PC_W-1:0]    q_head_pc;
    logic [INSTR_W-1:0] q_head_instr;

    logic             rsp_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] committed;
    logic [PC_W-1:0]  redirect_base;
    logic             unused_pc_lsbs;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_ok = imem_rvalid & (outstanding_q != '0);

    // Slots already owed to live requests: queued words plus in-flight words that will be kept
    assign committed = {1'b0, q_count} + {1'b0, outstanding_q} - {1'b0, drop_cnt_q};

    // Issue only when the accepted word is guaranteed a queue slot
    assign imem_req  = reset_n & fetch_en & ~redirect
                     & (outstanding_q < CNT_W'(MAX_OUT))
                     & (committed < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req & imem_gnt;

    assign redirect_base  = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign push = rsp_ok & (drop_cnt_q == '0) & ~redirect;
    assign pop  = dec_valid & dec_ready & ~redirect;

    // Head is masked to zero while empty so idle/reset outputs read as zero
    assign dec_valid = ~q_empty;
    assign dec_instr = dec_valid ? q_head_instr : '0;
    assign dec_pc    = dec_valid ? q_head_pc : '0;

    if_queue_fifo #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .flush_i      (redirect),
        .push_i       (push),
        .push_pc_i    (resp_pc_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .head_pc_o    (q_head_pc),
        .head_instr_o (q_head_instr),
        .count_o      (q_count),
        .empty_o      (q_empty)
    );

    // Fetch/response PC tracking and in-flight bookkeeping; redirect overrides everything
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            fetch_pc_d    = redirect_base;
            resp_pc_d     = redirect_base;
            outstanding_d = outstanding_q - CNT_W'(rsp_ok);
            drop_cnt_d    = outstanding_q - CNT_W'(rsp_ok);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_W'(PC_INC);
            end
            outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_ok);
            if (rsp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_q + PC_W'(PC_INC);
                end
            end
        end
    end

    // Front-end state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= PC_W'(PC_RESET);
            resp_pc_q     <= PC_W'(PC_RESET);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Memory must never answer a request that was not made
    rvalid_needs_outstanding: assert property (
        @(posedge clock) disable iff (!reset_n)
        !(imem_rvalid && (outstanding_q == '0))
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed sequences with hand-listed expected
// request addresses and decode PCs, checked by negedge monitors.
module tb_if_fetch_queue;

    logic        clock;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    if_fetch_queue #(
        .PC_W    (32),
        .INSTR_W (32),
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int hs_total = 0;
    int cyc = 0;
    int first_hs = -1;
    int first_dv = -1;
    bit track = 1'b0;
    bit mem_hold = 1'b0;

    logic [31:0] exp_addr [$];
    logic [31:0] exp_dec  [$];
    logic [31:0] pend     [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_hs(input string name, input int base, input int n);
        int k;
        k = 0;
        while ((hs_total - base) < n && k < 100) begin
            next();
            k++;
        end
        check(name, 64'(hs_total - base), 64'(n));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_dec.size() != 0 || exp_addr.size() != 0) && k < 200) begin
            next();
            k++;
        end
        check(name, 64'(exp_dec.size() + exp_addr.size()), 64'd0);
        repeat (3) next();
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitors: request addresses and decode output
    always @(negedge clock) begin
        logic [31:0] p;
        if (reset_n) begin
            if (imem_req && imem_gnt) begin
                if (track && first_hs < 0) first_hs = cyc;
                hs_total++;
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL imem_addr_unexpected: got 0x%0h, required no request", imem_addr);
                end else begin
                    check("imem_addr", {32'd0, imem_addr}, {32'd0, exp_addr.pop_front()});
                end
            end
            if (track && first_dv < 0 && dec_valid) first_dv = cyc;
            if (dec_valid && dec_ready && !redirect) begin
                if (exp_dec.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dec_unexpected: got pc 0x%0h, required no word", dec_pc);
                end else begin
                    p = exp_dec.pop_front();
                    check("dec_pc", {32'd0, dec_pc}, {32'd0, p});
                    check("dec_instr", {32'd0, dec_instr}, {32'd0, instr_of(p)});
                end
            end
        end
    end

    // Memory model: answers each accepted request in order, one cycle later unless held
    initial begin
        bit          hs;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clock);
            hs = reset_n && imem_req && imem_gnt;
            a  = imem_addr;
            @(posedge clock);
            #1;
            if (hs) pend.push_back(a);
            if (!mem_hold && pend.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset_n     = 1'b0;
        fetch_en    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        dec_ready   = 1'b1;
        repeat (3) @(posedge clock);
        #2;

        // Reset state, with fetch_en already high
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_pc", 64'(dec_pc), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'd0);

        // Streaming: six sequential words
        for (int i = 0; i < 6; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_dec.push_back(32'(4 * i));
        end
        track   = 1'b1;
        reset_n = 1'b1;
        wait_hs("t1_issue", 0, 6);
        fetch_en = 1'b0;
        drain("t1_drain");
        track = 1'b0;
        check("t1_latency", 64'(first_dv - first_hs), 64'd2);

        // Back-pressure: queue fills to DEPTH, issue stops
        dec_ready = 1'b0;
        fetch_en  = 1'b1;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'(24 + 4 * i));
        base = hs_total;
        repeat (12) next();
        @(negedge clock);
        check("t2_issued", 64'(hs_total - base), 64'd4);
        check("t2_req_blocked", 64'(imem_req), 64'd0);
        check("t2_head_valid", 64'(dec_valid), 64'd1);
        check("t2_head_pc", 64'(dec_pc), 64'h18);
        next();
        for (int i = 0; i < 8; i++) exp_dec.push_back(32'(24 + 4 * i));
        for (int i = 4; i < 8; i++) exp_addr.push_back(32'(24 + 4 * i));
        base = hs_total;
        dec_ready = 1'b1;
        @(negedge clock);
        check("t2_req_before_pop", 64'(imem_req), 64'd0);
        next();
        @(negedge clock);
        check("t2_req_after_pop", 64'(imem_req), 64'd1);
        next();
        wait_hs("t2_resume", base, 4);
        fetch_en = 1'b0;
        drain("t2_drain");

        // Redirect with two requests in flight
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        next();
        redirect = 1'b0;
        mem_hold = 1'b1;
        fetch_en = 1'b1;
        exp_addr.push_back(32'h10);
        exp_addr.push_back(32'h14);
        base = hs_total;
        wait_hs("t3_issue", base, 2);
        repeat (2) next();
        @(negedge clock);
        check("t3_max_out", 64'(imem_req), 64'd0);
        next();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clock);
        check("t3_redir_no_req", 64'(imem_req), 64'd0);
        next();
        redirect = 1'b0;
        mem_hold = 1'b0;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        exp_dec.push_back(32'h100);
        exp_dec.push_back(32'h104);
        base = hs_total;
        @(negedge clock);
        check("t3_redir_addr", 64'(imem_addr), 64'h100);
        next();
        wait_hs("t3_refetch", base, 2);
        fetch_en = 1'b0;
        drain("t3_drain");

        // Redirect coinciding with a response and a decode pop
        dec_ready = 1'b0;
        mem_hold  = 1'b1;
        fetch_en  = 1'b1;
        exp_addr.push_back(32'h108);
        exp_addr.push_back(32'h10C);
        base = hs_total;
        wait_hs("t4_issue", base, 2);
        fetch_en = 1'b0;
        mem_hold = 1'b0;
        next();
        mem_hold = 1'b1;
        next();
        fetch_en = 1'b1;
        exp_addr.push_back(32'h110);
        base = hs_total;
        wait_hs("t4_issue2", base, 1);
        fetch_en = 1'b0;
        mem_hold = 1'b0;
        next();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        dec_ready   = 1'b1;
        @(negedge clock);
        check("t4_redir_no_req", 64'(imem_req), 64'd0);
        check("t4_head_before", 64'(dec_valid), 64'd1);
        next();
        redirect = 1'b0;
        exp_dec.delete();
        exp_dec.push_back(32'h200);
        exp_dec.push_back(32'h204);
        exp_addr.push_back(32'h200);
        exp_addr.push_back(32'h204);
        base = hs_total;
        fetch_en = 1'b1;
        @(negedge clock);
        check("t4_flushed", 64'(dec_valid), 64'd0);
        check("t4_flushed_pc", 64'(dec_pc), 64'd0);
        next();
        wait_hs("t4_refetch", base, 2);
        fetch_en = 1'b0;
        drain("t4_drain");

        // Address wrap at the top of the PC space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        next();
        redirect = 1'b0;
        exp_addr.push_back(32'hFFFF_FFF8);
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_dec.push_back(32'hFFFF_FFF8);
        exp_dec.push_back(32'hFFFF_FFFC);
        exp_dec.push_back(32'h0);
        exp_dec.push_back(32'h4);
        base = hs_total;
        fetch_en = 1'b1;
        @(negedge clock);
        check("t5_masked_addr", 64'(imem_addr), 64'hFFFF_FFF8);
        next();
        wait_hs("t5_issue", base, 4);
        fetch_en = 1'b0;
        drain("t5_drain");

        // Asynchronous reset with a queued word and two requests in flight
        dec_ready = 1'b0;
        fetch_en  = 1'b1;
        exp_addr.push_back(32'h8);
        base = hs_total;
        wait_hs("t6_issue", base, 1);
        fetch_en = 1'b0;
        repeat (3) next();
        mem_hold = 1'b1;
        fetch_en = 1'b1;
        exp_addr.push_back(32'hC);
        exp_addr.push_back(32'h10);
        base = hs_total;
        wait_hs("t6_issue2", base, 2);
        check("t6_pre_valid", 64'(dec_valid), 64'd1);
        reset_n     = 1'b0;
        pend.delete();
        imem_rvalid = 1'b0;
        mem_hold    = 1'b0;
        #1;
        check("t6_rst_req", 64'(imem_req), 64'd0);
        check("t6_rst_valid", 64'(dec_valid), 64'd0);
        check("t6_rst_pc", 64'(dec_pc), 64'd0);
        check("t6_rst_instr", 64'(dec_instr), 64'd0);
        exp_addr.delete();
        exp_dec.delete();
        repeat (2) next();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_dec.push_back(32'h0);
        exp_dec.push_back(32'h4);
        base = hs_total;
        reset_n   = 1'b1;
        dec_ready = 1'b1;
        wait_hs("t6_after_reset", base, 2);
        fetch_en = 1'b0;
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
